clk_switch_ctrl: RTL and testbench
==================================

CLK_SWITCH_CTRL -- requirements
Module: clk_switch_ctrl

Interface
REQ-001 Parameter ACK_TIMEOUT, default 64, max clk cycles to wait for sw_ack to match the target source.
REQ-002 Parameter SETTLE_CYCLES, default 8, clk cycles held after ack before the switch is declared complete.
REQ-003 Parameter MON_WINDOW, default 32, clk cycles without primary activity before the primary is declared failed.
REQ-004 clk  in  1  the single controller clock (always-on reference).
REQ-005 rst  in  1  reset: asynchronous, active-high.
REQ-006 req_valid  in  1  switch request valid.
REQ-007 req_sel  in  1  requested source: 0 = primary, 1 = backup.
REQ-008 req_ready  out  1  controller accepts a request this cycle.
REQ-009 sw_ack  in  1  source currently selected by the clock mux, already synchronized to clk.
REQ-010 prim_tick  in  1  primary-clock toggle, already synchronized to clk; any level change is activity.
REQ-011 auto_fail_en  in  1  enables automatic failover to backup.
REQ-012 clr_fail  in  1  single-cycle pulse clearing fail_flag and the activity counter.
REQ-013 switch_en  out  1  select drive to the clock mux (0 primary, 1 backup).
REQ-014 cur_sel  out  1  committed source after settle.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 fail_flag  out  1  sticky primary-failure indication.
REQ-017 err_timeout  out  1  single-cycle pulse on ack timeout.

Function
REQ-018 FSM states: IDLE, DRIVE, WAIT_ACK, SETTLE.
REQ-019 req_ready = 1 only in IDLE with rst low; a handshake is req_valid && req_ready.
REQ-020 Handshake in cycle N with req_sel != cur_sel: target latched, switch_en = target at N+1, state DRIVE at N+1, WAIT_ACK at N+2.
REQ-021 Handshake with req_sel == cur_sel: consumed, no state change, no output change.
REQ-022 WAIT_ACK: when sw_ack == target, enter SETTLE; the ack wait counter starts at 0 on entry.
REQ-023 SETTLE lasts exactly SETTLE_CYCLES cycles, then cur_sel = target and the FSM returns to IDLE in the same cycle.
REQ-024 If sw_ack != target for ACK_TIMEOUT cycles in WAIT_ACK: switch_en reverts to cur_sel, err_timeout pulses 1 cycle, FSM returns to IDLE, cur_sel unchanged.
REQ-025 sw_ack deviating from target during SETTLE restarts WAIT_ACK without resetting the timeout count.
REQ-026 Activity counter increments each cycle prim_tick is unchanged, clears on any change, and saturates at MON_WINDOW.
REQ-027 Counter reaching MON_WINDOW sets fail_flag; fail_flag holds until clr_fail or rst.
REQ-028 In IDLE with auto_fail_en = 1, fail_flag = 1 and cur_sel = 0: an internal request to backup starts, with priority over req_valid in the same cycle (req_ready = 0 that cycle).
REQ-029 While fail_flag = 1, external requests for primary are consumed and discarded.
REQ-030 clr_fail coincident with counter saturation: clear wins.
REQ-031 The counter runs in all states; fail_flag never aborts a switch in progress.

Reset
REQ-032 rst asserted, at any time including mid-switch: state IDLE, switch_en = 0, cur_sel = 0, busy = 0, fail_flag = 0, err_timeout = 0, req_ready = 0, all counters 0.
REQ-033 req_ready rises in the first clk cycle after rst deasserts.

Structure
REQ-034 Shared package clk_switch_pkg holds the FSM state enum and the source encodings SEL_PRIMARY = 0 and SEL_BACKUP = 1.
REQ-035 The primary activity counter and fail_flag logic live in sub-module clk_activity_mon; the FSM lives in clk_switch_ctrl.

Verification
REQ-036 Request backup, sw_ack follows after 3 cycles -> switch_en = 1 at N+1, cur_sel = 1 after SETTLE_CYCLES = 8, no err_timeout.
REQ-037 Request backup, sw_ack held at 0 -> err_timeout pulse after 64 cycles in WAIT_ACK, switch_en back to 0, cur_sel = 0.
REQ-038 prim_tick frozen for 32 cycles with auto_fail_en = 1 -> fail_flag = 1, autonomous switch, cur_sel = 1; a subsequent primary request is discarded.
REQ-039 rst asserted during SETTLE -> all outputs at reset values immediately; req_ready = 1 one cycle after release.
REQ-040 Failover trigger and external req_valid in the same IDLE cycle -> failover wins, external request held until IDLE; clr_fail then clears fail_flag.

Source files
------------

// File: rtl/clk_switch_pkg.sv
// Shared types and encodings for the clock-source switch controller.
package clk_switch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRIVE    = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_SETTLE   = 2'd3
  } sw_state_e;

  localparam logic SEL_PRIMARY = 1'b0;
  localparam logic SEL_BACKUP  = 1'b1;

  // Bits needed to hold any value in 0..max_val (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 32'd1);
    if (w < 32'd1) begin
      w = 32'd1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/clk_activity_mon.sv
// Primary-clock activity monitor: counts cycles without a prim_tick level
// change and raises a sticky fail_flag once MON_WINDOW is reached.
module clk_activity_mon
  import clk_switch_pkg::*;
#(
  parameter int MON_WINDOW = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic prim_tick,
  input  logic clr_fail,
  output logic fail_flag
);

  localparam int CW = int'(cnt_width(MON_WINDOW));
  localparam logic [CW-1:0] CNT_MAX = CW'(MON_WINDOW);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          prev_tick_r;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_next_s;
  logic          fail_r;

  // Next idle count: clear request beats saturation, any level change restarts.
  always_comb begin
    cnt_next_s = cnt_r;
    if (clr_fail) begin
      cnt_next_s = '0;
    end else if (prim_tick != prev_tick_r) begin
      cnt_next_s = '0;
    end else if (cnt_r != CNT_MAX) begin
      cnt_next_s = cnt_r + CNT_ONE;
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Tick history, idle counter and sticky failure flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_tick_r <= 1'b0;
      cnt_r       <= '0;
      fail_r      <= 1'b0;
    end else begin
      prev_tick_r <= prim_tick;
      cnt_r       <= cnt_next_s;
      if (clr_fail) begin
        fail_r <= 1'b0;
      end else if (cnt_next_s == CNT_MAX) begin
        fail_r <= 1'b1;
      end else begin
        fail_r <= fail_r;
      end
    end
  end

  assign fail_flag = fail_r;

endmodule

// File: rtl/clk_switch_ctrl.sv
// Clock-source switch controller: drives the mux select, waits for the mux
// acknowledge, holds a settle window, and fails over to backup on demand.
module clk_switch_ctrl
  import clk_switch_pkg::*;
#(
  parameter int ACK_TIMEOUT   = 64,
  parameter int SETTLE_CYCLES = 8,
  parameter int MON_WINDOW    = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  input  logic req_sel,
  output logic req_ready,
  input  logic sw_ack,
  input  logic prim_tick,
  input  logic auto_fail_en,
  input  logic clr_fail,
  output logic switch_en,
  output logic cur_sel,
  output logic busy,
  output logic fail_flag,
  output logic err_timeout
);

  localparam int AW = int'(cnt_width(ACK_TIMEOUT));
  localparam int SW = int'(cnt_width(SETTLE_CYCLES));
  localparam logic [AW-1:0] ACK_LAST    = AW'(ACK_TIMEOUT - 1);
  localparam logic [AW-1:0] ACK_ONE     = AW'(1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_ONE  = SW'(1);

  sw_state_e     state_r, state_next_s;
  logic          target_r, target_next_s;
  logic          switch_en_r, switch_en_next_s;
  logic          cur_sel_r, cur_sel_next_s;
  logic [AW-1:0] ack_cnt_r, ack_cnt_next_s;
  logic [SW-1:0] settle_cnt_r, settle_cnt_next_s;
  logic          err_r, err_next_s;
  logic          fail_flag_s;
  logic          failover_s;
  logic          accept_s;

  clk_activity_mon #(
    .MON_WINDOW(MON_WINDOW)
  ) u_mon (
    .clk      (clk),
    .rst      (rst),
    .prim_tick(prim_tick),
    .clr_fail (clr_fail),
    .fail_flag(fail_flag_s)
  );

  // Failover outranks any external request presented in the same cycle.
  assign failover_s = (state_r == ST_IDLE) && auto_fail_en && fail_flag_s &&
                      (cur_sel_r == SEL_PRIMARY);
  assign req_ready  = (state_r == ST_IDLE) && !rst && !failover_s;
  // Requests that would not change the source, or that ask for a failed primary, are dropped.
  assign accept_s   = req_valid && req_ready && (req_sel != cur_sel_r) &&
                      !(fail_flag_s && (req_sel == SEL_PRIMARY));

  // Next-state and next-output logic.
  always_comb begin
    state_next_s      = state_r;
    target_next_s     = target_r;
    switch_en_next_s  = switch_en_r;
    cur_sel_next_s    = cur_sel_r;
    ack_cnt_next_s    = ack_cnt_r;
    settle_cnt_next_s = settle_cnt_r;
    err_next_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (failover_s) begin
          target_next_s    = SEL_BACKUP;
          switch_en_next_s = SEL_BACKUP;
          state_next_s     = ST_DRIVE;
        end else if (accept_s) begin
          target_next_s    = req_sel;
          switch_en_next_s = req_sel;
          state_next_s     = ST_DRIVE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        ack_cnt_next_s = '0;
        state_next_s   = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (sw_ack == target_r) begin
          settle_cnt_next_s = '0;
          state_next_s      = ST_SETTLE;
        end else if (ack_cnt_r == ACK_LAST) begin
          switch_en_next_s = cur_sel_r;
          err_next_s       = 1'b1;
          state_next_s     = ST_IDLE;
        end else begin
          ack_cnt_next_s = ack_cnt_r + ACK_ONE;
        end
      end
      ST_SETTLE: begin
        // A lost ack re-enters the wait but keeps the timeout budget already spent.
        if (sw_ack != target_r) begin
          state_next_s = ST_WAIT_ACK;
        end else if (settle_cnt_r == SETTLE_LAST) begin
          cur_sel_next_s = target_r;
          state_next_s   = ST_IDLE;
        end else begin
          settle_cnt_next_s = settle_cnt_r + SETTLE_ONE;
        end
      end
      default: begin
        switch_en_next_s = cur_sel_r;
        state_next_s     = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      target_r     <= SEL_PRIMARY;
      switch_en_r  <= SEL_PRIMARY;
      cur_sel_r    <= SEL_PRIMARY;
      ack_cnt_r    <= '0;
      settle_cnt_r <= '0;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      target_r     <= target_next_s;
      switch_en_r  <= switch_en_next_s;
      cur_sel_r    <= cur_sel_next_s;
      ack_cnt_r    <= ack_cnt_next_s;
      settle_cnt_r <= settle_cnt_next_s;
      err_r        <= err_next_s;
    end
  end

  assign switch_en   = switch_en_r;
  assign cur_sel     = cur_sel_r;
  assign busy        = (state_r != ST_IDLE);
  assign fail_flag   = fail_flag_s;
  assign err_timeout = err_r;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Scoreboard bench for clk_switch_ctrl: stimulus predicts output events from
// the timing rules, a negedge monitor pops and compares them as they occur.
module tb_clk_switch_ctrl;

  localparam int ACK_TIMEOUT   = 64;
  localparam int SETTLE_CYCLES = 8;
  localparam int MON_WINDOW    = 32;
  localparam int K_SW   = 0;
  localparam int K_CUR  = 1;
  localparam int K_ERR  = 2;
  localparam int K_FAIL = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0, req_sel = 1'b0, sw_ack = 1'b0, prim_tick = 1'b0;
  logic auto_fail_en = 1'b0, clr_fail = 1'b0;
  logic req_ready, switch_en, cur_sel, busy, fail_flag, err_timeout;

  clk_switch_ctrl #(
    .ACK_TIMEOUT(ACK_TIMEOUT), .SETTLE_CYCLES(SETTLE_CYCLES), .MON_WINDOW(MON_WINDOW)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_sel(req_sel), .req_ready(req_ready),
    .sw_ack(sw_ack), .prim_tick(prim_tick), .auto_fail_en(auto_fail_en), .clr_fail(clr_fail),
    .switch_en(switch_en), .cur_sel(cur_sel), .busy(busy), .fail_flag(fail_flag),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {int kind; int val; int cyc;} ev_t;
  ev_t exp_q[$];
  bit  mon_en = 1'b0;
  logic p_sw = 1'b0, p_cur = 1'b0, p_fail = 1'b0;
  int  model_cur = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int val, input int c);
    exp_q.push_back('{kind, val, c});
  endtask

  task automatic see_event(input int kind, input int val);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d value %0d at cycle %0d, required none",
               kind, val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val || e.cyc != cyc) begin
        n_fail++;
        $display("FAIL event: got kind %0d value %0d cycle %0d, required kind %0d value %0d cycle %0d",
                 kind, val, cyc, e.kind, e.val, e.cyc);
      end
    end
  endtask

  // Monitor: any change on the observed outputs is an event for the scoreboard.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (switch_en !== p_sw)    see_event(K_SW, int'(switch_en));
      if (cur_sel !== p_cur)     see_event(K_CUR, int'(cur_sel));
      if (err_timeout === 1'b1)  see_event(K_ERR, 1);
      if (fail_flag !== p_fail)  see_event(K_FAIL, int'(fail_flag));
    end
    p_sw   <= switch_en;
    p_cur  <= cur_sel;
    p_fail <= fail_flag;
  end

  // Clock-mux model: sw_ack follows switch_en after mux_delay mismatched cycles.
  int mux_delay = 1;
  int mis = 0;
  bit mux_auto = 1'b1;
  always @(posedge clk) begin
    #1;
    if (mux_auto && switch_en !== sw_ack) begin
      mis = mis + 1;
      if (mis >= mux_delay) begin
        sw_ack = switch_en;
        mis = 0;
      end
    end else begin
      mis = 0;
    end
  end

  // Primary clock activity: toggles at least every third cycle while running.
  bit tick_run = 1'b1;
  int last_tick = 0;
  int since = 0;
  always @(posedge clk) begin
    #1;
    if (tick_run) begin
      since = since + 1;
      if (since >= 3 || $urandom_range(0, 1) == 1) begin
        prim_tick = ~prim_tick;
        last_tick = cyc;
        since = 0;
      end
    end
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Holds req_valid until accepted; n is the handshake cycle or -1 on timeout.
  task automatic do_req(input logic sel, output int n);
    int budget;
    budget = 0;
    n = -1;
    req_valid = 1'b1;
    req_sel = sel;
    while (n < 0 && budget < 400) begin
      @(negedge clk);
      if (req_ready === 1'b1) n = cyc;
      else budget++;
    end
    if (n < 0) check("req_handshake", 32'd0, 32'd1);
    @(posedge clk);
    #2;
    req_valid = 1'b0;
  endtask

  task automatic switch_to(input int tgt, input int delay);
    int n, s, done;
    mux_delay = delay;
    do_req(tgt[0], n);
    if (n >= 0) begin
      push(K_SW, tgt, n + 1);
      if (delay <= ACK_TIMEOUT + 1) begin
        s = (n + delay > n + 2) ? n + delay : n + 2;
        done = s + 1 + SETTLE_CYCLES;
        push(K_CUR, tgt, done);
        model_cur = tgt;
      end else begin
        done = n + 2 + ACK_TIMEOUT;
        push(K_SW, model_cur, done);
        push(K_ERR, 1, done);
      end
      check("busy_in_switch", busy, 32'd1);
      goto(done + 1);
      check("idle_after_switch", busy, 32'd0);
      check("cur_sel_after_switch", cur_sel, model_cur);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t, f, c;
    repeat (3) @(posedge clk);
    #2;
    check("rst_switch_en", switch_en, 32'd0);
    check("rst_cur_sel", cur_sel, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_fail_flag", fail_flag, 32'd0);
    check("rst_err_timeout", err_timeout, 32'd0);
    check("rst_req_ready", req_ready, 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", req_ready, 32'd1);
    mon_en = 1'b1;

    switch_to(1, 3);
    switch_to(0, 3);
    switch_to(1, 1000);
    switch_to(1, ACK_TIMEOUT + 1);
    switch_to(0, ACK_TIMEOUT + 2);
    switch_to(0, 1);
    do_req(1'b0, n);
    check("same_sel_consumed", busy, 32'd0);
    for (int i = 0; i < 6; i++) begin
      switch_to(1 - model_cur, int'($urandom_range(1, 80)));
    end
    if (model_cur != 0) switch_to(0, 2);

    // Ack lost during settle: wait is re-entered, then a full settle follows.
    mux_auto = 1'b0;
    do_req(1'b1, n);
    push(K_SW, 1, n + 1);
    push(K_CUR, 1, n + 16);
    goto(n + 2); sw_ack = 1'b1;
    goto(n + 5); sw_ack = 1'b0;
    goto(n + 7); sw_ack = 1'b1;
    goto(n + 17);
    check("glitch_cur_sel", cur_sel, 32'd1);
    model_cur = 1;
    mux_auto = 1'b1;
    switch_to(0, 2);

    // Clear coincident with saturation wins; the flag re-arms a full window later.
    auto_fail_en = 1'b0;
    @(negedge clk); tick_run = 1'b0;
    @(posedge clk); #2;
    t = last_tick;
    push(K_FAIL, 1, t + 65);
    goto(t + 32); clr_fail = 1'b1;
    goto(t + 33); clr_fail = 1'b0;
    check("clr_wins", fail_flag, 32'd0);
    goto(t + 66); tick_run = 1'b1;
    goto(t + 70); clr_fail = 1'b1;
    push(K_FAIL, 0, t + 71);
    goto(t + 71); clr_fail = 1'b0;

    // Failover against a concurrent external request.
    auto_fail_en = 1'b1;
    mux_delay = 4;
    goto(cyc + 5);
    @(negedge clk); tick_run = 1'b0;
    @(posedge clk); #2;
    t = last_tick;
    f = t + MON_WINDOW + 1;
    push(K_FAIL, 1, f);
    push(K_SW, 1, f + 1);
    push(K_CUR, 1, f + 4 + 1 + SETTLE_CYCLES);
    goto(f);
    req_valid = 1'b1; req_sel = 1'b1;
    @(negedge clk);
    check("ready_low_on_failover", req_ready, 32'd0);
    do_req(1'b1, n);
    check("ext_req_held_until_idle", n, f + 4 + 1 + SETTLE_CYCLES);
    model_cur = 1;
    check("backup_req_consumed", busy, 32'd0);
    do_req(1'b0, n);
    check("primary_req_discarded", busy, 32'd0);
    check("cur_sel_stays_backup", cur_sel, 32'd1);
    tick_run = 1'b1;
    goto(cyc + 4);
    c = cyc;
    clr_fail = 1'b1;
    push(K_FAIL, 0, c + 1);
    goto(c + 1); clr_fail = 1'b0;
    switch_to(0, 2);

    // Reset in the middle of the settle window.
    mux_delay = 1;
    do_req(1'b1, n);
    push(K_SW, 1, n + 1);
    goto(n + 5);
    check("settle_busy", busy, 32'd1);
    mon_en = 1'b0;
    check("queue_before_rst", exp_q.size(), 32'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_switch_en", switch_en, 32'd0);
    check("mid_rst_cur_sel", cur_sel, 32'd0);
    check("mid_rst_busy", busy, 32'd0);
    check("mid_rst_fail_flag", fail_flag, 32'd0);
    check("mid_rst_err_timeout", err_timeout, 32'd0);
    check("mid_rst_req_ready", req_ready, 32'd0);
    goto(n + 7);
    rst = 1'b0;
    #1;
    check("ready_after_mid_rst", req_ready, 32'd1);
    model_cur = 0;
    goto(cyc + 3);
    mon_en = 1'b1;
    switch_to(1, 5);

    goto(cyc + 5);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
